// File: rtl/vga_scan_timing.sv
// 640x480@60 raster timing with a one-pixel output register stage.
// Colour from the external lookup is blanked and registered alongside the syncs.
module vga_scan_timing #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] x,
  output logic [8:0] y,
  input  logic [3:0] r_in,
  input  logic [3:0] g_in,
  input  logic [3:0] b_in,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       video_on,
  output logic       frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [3:0] DIV_MAX = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_MAX   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [3:0] div_q, div_d;
  logic [9:0] h_q, h_d, v_q, v_d;
  logic       pix_tick, h_wrap, v_wrap, act, hs_n, vs_n;

  always_comb begin
    pix_tick = (div_q == DIV_MAX);
    div_d    = pix_tick ? 4'd0 : div_q + 4'd1;
    h_wrap   = (h_q == H_MAX);
    v_wrap   = (v_q == V_MAX);
    h_d      = h_q;
    v_d      = v_q;
    if (pix_tick) begin
      h_d = h_wrap ? 10'd0 : h_q + 10'd1;
      if (h_wrap) v_d = v_wrap ? 10'd0 : v_q + 10'd1;
    end
    act  = (h_q < H_ACT) && (v_q < V_ACT);
    hs_n = !((h_q >= HS_BEG) && (h_q <= HS_END));
    vs_n = !((v_q >= VS_BEG) && (v_q <= VS_END));
    x    = (h_q < H_ACT) ? h_q : 10'd0;
    y    = (v_q < V_ACT) ? v_q[8:0] : 9'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q       <= '0;
      h_q         <= '0;
      v_q         <= '0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      video_on    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div_q       <= div_d;
      h_q         <= h_d;
      v_q         <= v_d;
      frame_start <= pix_tick && h_wrap && v_wrap;
      // Output stage samples the decode of the pixel being left, so DAC lags counters by one pixel.
      if (pix_tick) begin
        vga_hs   <= hs_n;
        vga_vs   <= vs_n;
        video_on <= act;
        vga_r    <= act ? r_in : 4'd0;
        vga_g    <= act ? g_in : 4'd0;
        vga_b    <= act ? b_in : 4'd0;
      end
    end
  end
endmodule

// File: tb/tb_vga_scan_timing.sv
// Scoreboard bench: three instances (full VGA div 2, small raster div 1 and div 3)
// compared every clock against a closed-form position model.
module tb_vga_scan_timing;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst;
  logic [9:0] x_o   [3];
  logic [8:0] y_o   [3];
  logic [3:0] r_o   [3];
  logic [3:0] g_o   [3];
  logic [3:0] b_o   [3];
  logic       hs_o  [3];
  logic       vs_o  [3];
  logic       von_o [3];
  logic       fs_o  [3];

  vga_scan_timing u_a (
    .clk(clk), .rst(rst[0]), .x(x_o[0]), .y(y_o[0]),
    .r_in(x_o[0][3:0]), .g_in(4'hA), .b_in(y_o[0][3:0]),
    .vga_r(r_o[0]), .vga_g(g_o[0]), .vga_b(b_o[0]),
    .vga_hs(hs_o[0]), .vga_vs(vs_o[0]), .video_on(von_o[0]), .frame_start(fs_o[0]));

  vga_scan_timing #(.CLK_DIV(1), .H_ACTIVE(20), .H_FP(4), .H_SYNC(6), .H_BP(5),
                    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)) u_b (
    .clk(clk), .rst(rst[1]), .x(x_o[1]), .y(y_o[1]),
    .r_in(x_o[1][3:0]), .g_in(4'hA), .b_in(y_o[1][3:0]),
    .vga_r(r_o[1]), .vga_g(g_o[1]), .vga_b(b_o[1]),
    .vga_hs(hs_o[1]), .vga_vs(vs_o[1]), .video_on(von_o[1]), .frame_start(fs_o[1]));

  vga_scan_timing #(.CLK_DIV(3), .H_ACTIVE(20), .H_FP(4), .H_SYNC(6), .H_BP(5),
                    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)) u_c (
    .clk(clk), .rst(rst[2]), .x(x_o[2]), .y(y_o[2]),
    .r_in(x_o[2][3:0]), .g_in(4'hA), .b_in(y_o[2][3:0]),
    .vga_r(r_o[2]), .vga_g(g_o[2]), .vga_b(b_o[2]),
    .vga_hs(hs_o[2]), .vga_vs(vs_o[2]), .video_on(von_o[2]), .frame_start(fs_o[2]));

  typedef struct {
    int div, ha, hf, hs, hb, va, vf, vs, vb;
  } geo_t;

  geo_t        G [3];
  int          checks = 0;
  int          errors = 0;
  logic [34:0] sb [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected outputs after n clocks since reset release: {x,y,r,g,b,hs,vs,on,fs}.
  function automatic logic [34:0] expect_out(input geo_t g, input int n);
    int ht = g.ha + g.hf + g.hs + g.hb;
    int vt = g.va + g.vf + g.vs + g.vb;
    int t  = n / g.div;
    int p  = t % (ht * vt);
    int h  = p % ht;
    int v  = p / ht;
    int q, hq, vq;
    logic [9:0] ex;
    logic [8:0] ey;
    logic [3:0] er = 4'd0, eg = 4'd0, eb = 4'd0;
    logic ehs = 1'b1, evs = 1'b1, eon = 1'b0, efs;
    ex  = (h < g.ha) ? 10'(h) : 10'd0;
    ey  = (v < g.va) ? 9'(v) : 9'd0;
    efs = (t > 0) && (n % g.div == 0) && (p == 0);
    if (t > 0) begin
      q   = (t - 1) % (ht * vt);
      hq  = q % ht;
      vq  = q / ht;
      eon = (hq < g.ha) && (vq < g.va);
      if (eon) begin
        er = 4'(hq);
        eg = 4'hA;
        eb = 4'(vq);
      end
      ehs = !(hq >= g.ha + g.hf && hq < g.ha + g.hf + g.hs);
      evs = !(vq >= g.va + g.vf && vq < g.va + g.vf + g.vs);
    end
    return {ex, ey, er, eg, eb, ehs, evs, eon, efs};
  endfunction

  initial begin
    int    n     [3] = '{0, 0, 0};
    bit    done  [3] = '{0, 0, 0};
    int    tgt_h [3] = '{300, 10, 10};
    int    tgt_v [3] = '{2, 8, 8};
    string nm    [3] = '{"A", "B", "C"};
    int    hs_run = 0, hs_first = -1;
    int    fs_last = -1, fs_per = -1;
    int    ymax_b = 0;
    logic [34:0] e, got;

    G[0] = '{2, 640, 16, 96, 48, 480, 10, 2, 33};
    G[1] = '{1, 20, 4, 6, 5, 12, 2, 2, 3};
    G[2] = '{3, 20, 4, 6, 5, 12, 2, 2, 3};
    rst  = 3'b111;

    for (int cyc = 0; cyc < 5600; cyc++) begin
      for (int k = 0; k < 3; k++) begin
        int ht, t, p;
        ht = G[k].ha + G[k].hf + G[k].hs + G[k].hb;
        t  = n[k] / G[k].div;
        p  = t % (ht * (G[k].va + G[k].vf + G[k].vs + G[k].vb));
        rst[k] = (cyc < 3) ||
                 (!done[k] && (p % ht) == tgt_h[k] && (p / ht) == tgt_v[k]);
        if (rst[k] && cyc >= 3) done[k] = 1'b1;
        n[k] = rst[k] ? 0 : n[k] + 1;
        sb.push_back(expect_out(G[k], n[k]));
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
        e   = sb.pop_front();
        got = {x_o[k], y_o[k], r_o[k], g_o[k], b_o[k], hs_o[k], vs_o[k], von_o[k], fs_o[k]};
        chk(nm[k], 64'(got), 64'(e));
      end
      if (!hs_o[0]) hs_run++;
      else begin
        if (hs_run > 0 && hs_first < 0) hs_first = hs_run;
        hs_run = 0;
      end
      if (fs_o[1]) begin
        if (fs_last >= 0 && fs_per < 0) fs_per = cyc - fs_last;
        fs_last = cyc;
      end
      if (int'(y_o[1]) > ymax_b) ymax_b = int'(y_o[1]);
      @(negedge clk);
    end

    chk("A.hs_width_clks", 64'(hs_first), 64'(192));
    chk("B.frame_period", 64'(fs_per), 64'(665));
    chk("B.y_max", 64'(ymax_b), 64'(11));
    chk("mid_resets_hit", 64'({done[0], done[1], done[2]}), 64'(3'b111));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
